// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with an iterative shift-add multiplier behind a valid/ready handshake
module alu_mc #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [3:0]   opcode,
   input  logic [N-1:0] op_a,
   input  logic [N-1:0] op_b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] result,
   output logic         flag_zero,
   output logic         flag_carry,
   output logic         flag_ovf,
   output logic         illegal_op
);
   localparam int CW = $clog2(N);
   typedef enum logic [1:0] {IDLE, MUL_BUSY, DONE} state_t;
   state_t state_q, state_d;
   logic [N-1:0]   res_q, res_d, mplier_q, mplier_d, alu_res;
   logic [2*N-1:0] mcand_q, mcand_d, acc_q, acc_d, mul_acc;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, ill_q, ill_d;
   logic           alu_c, alu_v, alu_ill;
   logic [N:0]     sum, diff, shr_t, shl_t;
   assign sum   = {1'b0, op_a} + {1'b0, op_b};
   assign diff  = {1'b0, op_a} - {1'b0, op_b};
   // one extra bit below/above the operand catches the last bit shifted out
   assign shr_t = {op_a, 1'b0} >> op_b;
   assign shl_t = {1'b0, op_a} << op_b;
   assign mul_acc = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign in_ready   = rst_n & (state_q == IDLE);
   assign out_valid  = state_q == DONE;
   assign result     = res_q;
   assign flag_zero  = zero_q;
   assign flag_carry = carry_q;
   assign flag_ovf   = ovf_q;
   assign illegal_op = ill_q;
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_ill = 1'b0;
      case (opcode)
         4'd0: begin
            alu_res = sum[N-1:0];
            alu_c   = sum[N];
            alu_v   = (op_a[N-1] == op_b[N-1]) && (sum[N-1] != op_a[N-1]);
         end
         4'd1: begin
            alu_res = diff[N-1:0];
            alu_c   = diff[N];
            alu_v   = (op_a[N-1] != op_b[N-1]) && (diff[N-1] != op_a[N-1]);
         end
         4'd2: alu_res = {{(N-1){1'b0}}, op_a < op_b};
         4'd3: alu_res = {{(N-1){1'b0}}, op_a == op_b};
         4'd4: alu_res = op_a | op_b;
         4'd5: alu_res = op_a & op_b;
         4'd6: alu_res = ~op_a;
         4'd7: alu_res = op_a ^ op_b;
         4'd8: alu_res = '0;
         4'd9: begin
            alu_res = shr_t[N:1];
            alu_c   = shr_t[0];
         end
         4'd10: begin
            alu_res = shl_t[N-1:0];
            alu_c   = shl_t[N];
         end
         default: alu_ill = 1'b1;
      endcase
   end
   always_comb begin
      state_d  = state_q;
      res_d    = res_q;
      zero_d   = zero_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
      ill_d    = ill_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: if (in_valid) begin
            if (opcode == 4'd8) begin
               state_d  = MUL_BUSY;
               mcand_d  = {{N{1'b0}}, op_a};
               mplier_d = op_b;
               acc_d    = '0;
               cnt_d    = '0;
            end else begin
               state_d = DONE;
               res_d   = alu_res;
               zero_d  = alu_res == '0;
               carry_d = alu_c;
               ovf_d   = alu_v;
               ill_d   = alu_ill;
            end
         end
         MUL_BUSY: begin
            acc_d    = mul_acc;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(N - 1)) begin
               state_d = DONE;
               res_d   = mul_acc[N-1:0];
               zero_d  = mul_acc[N-1:0] == '0;
               carry_d = |mul_acc[2*N-1:N];
               ovf_d   = 1'b0;
               ill_d   = 1'b0;
            end
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         res_q    <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         ill_q    <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         res_q    <= res_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
         ill_q    <= ill_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vectors for alu_mc checked against an arithmetic reference model every cycle
module tb_alu_mc;
   localparam int N = 32;
   localparam longint MAXS = 64'sd2147483647;
   localparam longint MINS = -64'sd2147483648;
   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [3:0]    opcode = '0;
   logic [N-1:0]  op_a = '0;
   logic [N-1:0]  op_b = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [N-1:0]  result;
   logic          flag_zero, flag_carry, flag_ovf, illegal_op;
   int            compared = 0;
   int            mismatched = 0;
   int            cyc = 0;
   int            due = 0;
   bit            pending = 1'b0;
   logic [35:0]   exp_q = '0;
   alu_mc #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .flag_zero(flag_zero),
      .flag_carry(flag_carry), .flag_ovf(flag_ovf), .illegal_op(illegal_op)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask
   // returns {illegal, ovf, carry, zero, result}
   function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r, tmp;
      logic        c, v, ill;
      longint      sa, sb, t;
      logic [63:0] p;
      r = '0; c = 1'b0; v = 1'b0; ill = 1'b0;
      sa = $signed(a);
      sb = $signed(b);
      case (op)
         4'd0: begin
            p = 64'(a) + 64'(b);
            r = p[31:0];
            c = p[32];
            t = sa + sb;
            v = (t > MAXS) || (t < MINS);
         end
         4'd1: begin
            r = a - b;
            c = a < b;
            t = sa - sb;
            v = (t > MAXS) || (t < MINS);
         end
         4'd2: r = (a < b) ? 32'd1 : 32'd0;
         4'd3: r = (a == b) ? 32'd1 : 32'd0;
         4'd4: r = a | b;
         4'd5: r = a & b;
         4'd6: r = ~a;
         4'd7: r = a ^ b;
         4'd8: begin
            p = {32'b0, a} * {32'b0, b};
            r = p[31:0];
            c = p[63:32] != 0;
         end
         4'd9: begin
            if (b == 0) r = a;
            else if (b <= 32) begin
               r = (b == 32) ? 32'd0 : a >> b;
               tmp = a >> (b - 1);
               c = tmp[0];
            end
         end
         4'd10: begin
            if (b == 0) r = a;
            else if (b <= 32) begin
               r = (b == 32) ? 32'd0 : a << b;
               tmp = a >> (32 - b);
               c = tmp[0];
            end
         end
         default: ill = 1'b1;
      endcase
      return {ill, v, c, (r == 0), r};
   endfunction
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending = 1'b0;
      else begin
         if (pending && cyc >= due && out_ready) pending = 1'b0;
         else if (!pending && in_valid) begin
            pending = 1'b1;
            exp_q = model(opcode, op_a, op_b);
            due = cyc + 1 + ((opcode == 4'd8) ? N : 0);
         end
         cyc++;
      end
   end
   always @(negedge clk) begin
      bit mv;
      mv = pending && cyc >= due;
      chk("in_ready", 64'(in_ready), 64'(rst_n && !pending));
      chk("out_valid", 64'(out_valid), 64'(mv));
      if (mv) begin
         chk("result", 64'(result), 64'(exp_q[31:0]));
         chk("flags", 64'({illegal_op, flag_ovf, flag_carry, flag_zero}), 64'(exp_q[35:32]));
      end else if (!rst_n) begin
         chk("rst_result", 64'(result), 64'd0);
         chk("rst_flags", 64'({illegal_op, flag_ovf, flag_carry, flag_zero}), 64'd0);
      end
   end
   task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int stall,
                      input int exp_lat, input logic [31:0] er, input logic [3:0] ef);
      int lat;
      @(negedge clk);
      in_valid = 1'b1; opcode = op; op_a = a; op_b = b; out_ready = 1'b0;
      @(posedge clk);
      #1;
      opcode = 4'($urandom); op_a = $urandom; op_b = $urandom;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 100);
      in_valid = 1'b0;
      chk("latency", 64'(lat), 64'(exp_lat));
      chk("lit_result", 64'(result), 64'(er));
      chk("lit_flags", 64'({illegal_op, flag_ovf, flag_carry, flag_zero}), 64'(ef));
      chk("busy_in_ready", 64'(in_ready), 64'd0);
      repeat (stall) @(negedge clk);
      if (stall > 0) begin
         chk("held_result", 64'(result), 64'(er));
         chk("held_valid", 64'(out_valid), 64'd1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk("ready_after", 64'(in_ready), 64'd1);
   endtask
   initial begin
      #1 rst_n = 1'b0;
      #2;
      chk("reset_valid", 64'(out_valid), 64'd0);
      chk("reset_ready", 64'(in_ready), 64'd0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      run(4'd0, 32'd15, 32'd10, 0, 1, 32'd25, 4'b0000);
      run(4'd0, 32'hFFFFFFFF, 32'd1, 0, 1, 32'd0, 4'b0011);
      run(4'd0, 32'h7FFFFFFF, 32'd1, 0, 1, 32'h80000000, 4'b0100);
      run(4'd8, 32'd5, 32'd10, 0, 33, 32'd50, 4'b0000);
      run(4'd8, 32'h10000, 32'h10000, 0, 33, 32'd0, 4'b0011);
      run(4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 33, 32'd1, 4'b0010);
      run(4'd10, 32'd10, 32'd1, 5, 1, 32'd20, 4'b0000);
      run(4'd9, 32'h80000000, 32'd40, 0, 1, 32'd0, 4'b0001);
      run(4'd9, 32'h80000001, 32'd1, 0, 1, 32'h40000000, 4'b0010);
      run(4'd9, 32'h80000000, 32'd32, 0, 1, 32'd0, 4'b0011);
      run(4'd10, 32'd1, 32'd32, 0, 1, 32'd0, 4'b0011);
      run(4'd9, 32'd5, 32'd0, 0, 1, 32'd5, 4'b0000);
      run(4'd15, 32'd3, 32'd4, 0, 1, 32'd0, 4'b1001);
      run(4'd1, 32'd5, 32'd10, 0, 1, 32'hFFFFFFFB, 4'b0010);
      run(4'd1, 32'h80000000, 32'd1, 0, 1, 32'h7FFFFFFF, 4'b0100);
      run(4'd2, 32'd5, 32'd10, 0, 1, 32'd1, 4'b0000);
      run(4'd3, 32'd20, 32'd20, 0, 1, 32'd1, 4'b0000);
      run(4'd6, 32'hF0F0F0F0, 32'h12345678, 0, 1, 32'h0F0F0F0F, 4'b0000);
      run(4'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 2, 1, 32'd0, 4'b0001);
      // reset in the middle of a multiply must drop it silently
      @(negedge clk);
      in_valid = 1'b1; opcode = 4'd8; op_a = 32'd7; op_b = 32'd3;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_valid", 64'(out_valid), 64'd0);
      chk("async_ready", 64'(in_ready), 64'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      run(4'd0, 32'd1, 32'd2, 0, 1, 32'd3, 4'b0000);
      // reset while a result is being held must clear it without a clock edge
      @(negedge clk);
      in_valid = 1'b1; opcode = 4'd4; op_a = 32'h0F; op_b = 32'hF0; out_ready = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      #2;
      chk("done_valid", 64'(out_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("done_async_valid", 64'(out_valid), 64'd0);
      chk("done_async_result", 64'(result), 64'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (40) @(negedge clk);
      run(4'd5, 32'hFF00FF00, 32'h0FF00FF0, 0, 1, 32'h0F000F00, 4'b0000);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning operand/result width in bits (N >= 2, power of two).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid  input  1  operation request valid.
REQ-005 The block SHALL have port in_ready  output  1  block can accept an operation.
REQ-006 The block SHALL have port opcode  input  4  operation select.
REQ-007 The block SHALL have ports op_a, op_b  input  N  operands.
REQ-008 The block SHALL have port out_valid  output  1  result valid.
REQ-009 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 The block SHALL have port result  output  N  operation result.
REQ-011 The block SHALL have ports flag_zero, flag_carry, flag_ovf, illegal_op  output  1 each  status flags qualified by out_valid.

Function
REQ-012 The opcodes SHALL be: 0 ADD, 1 SUB, 2 LESS, 3 EQ, 4 OR, 5 AND, 6 NOT, 7 XOR, 8 MUL, 9 SHR, 10 SHL; 11-15 illegal.
REQ-013 The FSM SHALL have states IDLE, MUL_BUSY and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; acceptance = in_valid & in_ready at a rising edge; opcode/op_a/op_b SHALL be latched at that edge.
REQ-015 Non-MUL ops (including illegal) SHALL go IDLE->DONE with out_valid high exactly 1 cycle after acceptance.
REQ-016 MUL SHALL go IDLE->MUL_BUSY, run iterative shift-add (one multiplier bit per cycle, N cycles), then DONE; out_valid rises N+1 cycles after acceptance.
REQ-017 In DONE: out_valid=1; result and flags held stable until out_valid & out_ready; then next state IDLE; no acceptance in the handshake cycle.
REQ-018 Input changes while not in IDLE SHALL be ignored.
REQ-019 ADD: result = (op_a+op_b) mod 2^N; flag_carry = carry-out; flag_ovf = signed overflow.
REQ-020 SUB: result = (op_a-op_b) mod 2^N; flag_carry = borrow (op_a < op_b unsigned); flag_ovf = signed overflow.
REQ-021 LESS/EQ: unsigned compare; result = zero-extended 1-bit outcome.
REQ-022 OR/AND/XOR bitwise; NOT: result = ~op_a, op_b ignored; carry and ovf = 0.
REQ-023 MUL: unsigned; result = low N bits of 2N-bit product; flag_carry = 1 iff upper N bits nonzero; flag_ovf = 0.
REQ-024 SHR/SHL: logical shift of op_a by op_b (unsigned amount); amount >= N -> result 0; flag_carry = last bit shifted out (0 when amount 0, 0 when amount > N, op_a MSB/LSB when amount = N); flag_ovf = 0.
REQ-025 flag_zero SHALL equal (result == 0) for every opcode.
REQ-026 Illegal opcode: result 0, illegal_op=1, flag_zero=1, carry/ovf 0; illegal_op=0 for legal ops.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, out_valid=0, in_ready=0, result=0, all flags 0, without waiting for clk.
REQ-028 Reset during MUL_BUSY or DONE SHALL discard the operation; no out_valid is produced for it.
REQ-029 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification (N=32)
REQ-030 ADD 15+10, out_ready=1 -> out_valid next cycle, result 25, all flags 0; ADD 0xFFFFFFFF+1 -> result 0, zero=1, carry=1, ovf=0; ADD 0x7FFFFFFF+1 -> 0x80000000, ovf=1.
REQ-031 MUL 5x10 -> in_ready 0 for 33 cycles, out_valid 33 cycles after acceptance, result 50; MUL 0x10000x0x10000 -> result 0, zero=1, carry=1.
REQ-032 SHL 10 by 1 with out_ready held 0 for 5 cycles -> result 20 stable and out_valid 1 throughout, in_ready 0; after handshake in_ready 1 next cycle.
REQ-033 SHR 0x80000000 by 40 -> result 0, zero=1, carry=0; SHR 0x80000001 by 1 -> 0x40000000, carry=1; opcode 15 -> result 0, illegal_op=1.
REQ-034 SUB 5-10 -> 0xFFFFFFFB, carry=1; LESS 5,10 -> 1; EQ 20,20 -> 1; NOT 0xF0F0F0F0 -> 0x0F0F0F0F.
REQ-035 rst_n pulsed low 10 cycles into MUL 7x3 -> out_valid 0 asynchronously, no result emitted; after release ADD 1+2 -> 3 with 1-cycle latency.
